spi_tx_fifo: RTL and testbench

Transmit-side byte buffer between the host write port and the SPI shift stage. Produces SENDER_FULL_STATE, SENDER_EMPTY_STATE and SENDER_BUFFER_FULL_STATE, which feed the status-combination block that builds the 8-bit STATUS word. Data is presented first-word-fall-through to the shifter over a valid/ready handshake. Holds up to DEPTH entries, plus a level count and a sticky overflow flag.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_fifo_mem.sv | 27 ++
 rtl/spi_tx_fifo.sv | 101 ++++++++++
 tb/tb_spi_tx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants: frame width, transmit buffer depth and the STATUS word layout.
// The TX_EMPTY pair (bits 4 and 5) is set after reset, which gives the 8'h30 reset value.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_TX_DEPTH   = 8;

  localparam int STAT_RX_FULL      = 2;
  localparam int STAT_TX_WRITE     = 3;
  localparam int STAT_TX_EMPTY     = 4;
  localparam int STAT_TX_EMPTY_ALT = 5;
  localparam int STAT_RX_NOT_EMPTY = 6;

  localparam logic [7:0] STATUS_RESET = 8'h30;

endpackage

// File: rtl/spi_fifo_mem.sv
// Register-array storage for the transmit buffer.
// Writes happen on the clock edge; reads are combinational so the head entry falls through.
module spi_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are never reset; the pointers decide what is valid.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_tx_fifo.sv
// Transmit byte buffer between the host write port and the SPI shifter.
// Registered occupancy flags, first-word-fall-through output and a sticky overflow flag.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int DEPTH       = SPI_TX_DEPTH,
  parameter int AFULL_LEVEL = 6,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  S_CLK,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  SENDER_WRITE,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  SENDER_FULL_STATE,
  output logic                  SENDER_EMPTY_STATE,
  output logic                  SENDER_BUFFER_FULL_STATE,
  output logic [CNT_W-1:0]      LEVEL,
  output logic                  OVERFLOW,
  input  logic                  ERR_CLR
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             afull_reg;
  logic             overflow_reg;
  logic             push;
  logic             pop;

  // A write while full is dropped even when a pop frees a slot in the same cycle.
  assign push = SENDER_WRITE & ~full_reg;
  assign pop  = ~empty_reg & TX_READY;

  always_comb begin
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge S_CLK or posedge CLR) begin
    if (CLR) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Flags are computed from count_next so they move on the same edge as count.
  always_ff @(posedge S_CLK or posedge CLR) begin
    if (CLR) begin
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      afull_reg <= 1'b0;
    end else begin
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
      afull_reg <= (count_next >= CNT_W'(AFULL_LEVEL));
    end
  end

  // A new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge S_CLK or posedge CLR) begin
    if (CLR) begin
      overflow_reg <= 1'b0;
    end else if (SENDER_WRITE && full_reg) begin
      overflow_reg <= 1'b1;
    end else if (ERR_CLR) begin
      overflow_reg <= 1'b0;
    end
  end

  spi_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (S_CLK),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (WR_DATA),
    .raddr (rd_ptr_reg),
    .rdata (TX_DATA)
  );

  assign TX_VALID                 = ~empty_reg;
  assign SENDER_FULL_STATE        = full_reg;
  assign SENDER_EMPTY_STATE       = empty_reg;
  assign SENDER_BUFFER_FULL_STATE = afull_reg;
  assign LEVEL                    = count_reg;
  assign OVERFLOW                 = overflow_reg;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed bench for spi_tx_fifo: reset, fill/drain, overflow, streaming, latency, async reset.
module tb_spi_tx_fifo;

  logic       S_CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] WR_DATA = '0;
  logic       SENDER_WRITE = 1'b0;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY = 1'b0;
  logic       SENDER_FULL_STATE;
  logic       SENDER_EMPTY_STATE;
  logic       SENDER_BUFFER_FULL_STATE;
  logic [3:0] LEVEL;
  logic       OVERFLOW;
  logic       ERR_CLR = 1'b0;

  int compared = 0;
  int mismatched = 0;

  spi_tx_fifo dut (
    .S_CLK                    (S_CLK),
    .CLR                      (CLR),
    .WR_DATA                  (WR_DATA),
    .SENDER_WRITE             (SENDER_WRITE),
    .TX_DATA                  (TX_DATA),
    .TX_VALID                 (TX_VALID),
    .TX_READY                 (TX_READY),
    .SENDER_FULL_STATE        (SENDER_FULL_STATE),
    .SENDER_EMPTY_STATE       (SENDER_EMPTY_STATE),
    .SENDER_BUFFER_FULL_STATE (SENDER_BUFFER_FULL_STATE),
    .LEVEL                    (LEVEL),
    .OVERFLOW                 (OVERFLOW),
    .ERR_CLR                  (ERR_CLR)
  );

  always #5 S_CLK = ~S_CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"}, SENDER_EMPTY_STATE, 1);
    check({tag, "_full"}, SENDER_FULL_STATE, 0);
    check({tag, "_bfull"}, SENDER_BUFFER_FULL_STATE, 0);
    check({tag, "_level"}, LEVEL, 0);
    check({tag, "_valid"}, TX_VALID, 0);
  endtask

  initial begin
    // 1. reset
    repeat (2) step();
    CLR = 1'b0;
    check_idle("reset");
    check("reset_ovf", OVERFLOW, 0);
    step();
    check_idle("reset_hold");

    // 2. fill 01..08 with the shifter stalled
    TX_READY = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      WR_DATA = 8'(i);
      SENDER_WRITE = 1'b1;
      step();
      check($sformatf("fill_level%0d", i), LEVEL, i);
      check($sformatf("fill_bfull%0d", i), SENDER_BUFFER_FULL_STATE, (i >= 6) ? 1 : 0);
      check($sformatf("fill_full%0d", i), SENDER_FULL_STATE, (i == 8) ? 1 : 0);
      check($sformatf("fill_empty%0d", i), SENDER_EMPTY_STATE, 0);
      check($sformatf("fill_head%0d", i), TX_DATA, 8'h01);
    end
    SENDER_WRITE = 1'b0;
    step();
    check("stall_head", TX_DATA, 8'h01);
    check("stall_level", LEVEL, 8);

    // drain in order
    TX_READY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_valid%0d", i), TX_VALID, 1);
      check($sformatf("drain_data%0d", i), TX_DATA, i);
      step();
      check($sformatf("drain_level%0d", i), LEVEL, 8 - i);
    end
    check_idle("drained");
    TX_READY = 1'b0;

    // 3. overflow: refill 11..18, then write AA while full with a pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      WR_DATA = 8'h11 + 8'(i);
      SENDER_WRITE = 1'b1;
      step();
    end
    check("ovf_full", SENDER_FULL_STATE, 1);
    check("ovf_pre", OVERFLOW, 0);
    WR_DATA = 8'hAA;
    TX_READY = 1'b1;
    step();
    SENDER_WRITE = 1'b0;
    TX_READY = 1'b0;
    check("ovf_flag", OVERFLOW, 1);
    check("ovf_level", LEVEL, 7);
    check("ovf_full_after", SENDER_FULL_STATE, 0);
    check("ovf_head", TX_DATA, 8'h12);
    step();
    check("ovf_sticky", OVERFLOW, 1);
    TX_READY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("ovf_drain%0d", i), TX_DATA, 8'h12 + 8'(i));
      step();
    end
    TX_READY = 1'b0;
    check_idle("ovf_drained");
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    check("errclr", OVERFLOW, 0);

    // 4. streaming at level 3; pointers start at 0, 3 preload + 10 pushes wrap past 7
    for (int i = 0; i < 3; i++) begin
      WR_DATA = 8'h21 + 8'(i);
      SENDER_WRITE = 1'b1;
      step();
    end
    check("stream_level0", LEVEL, 3);
    TX_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      WR_DATA = 8'h30 + 8'(k);
      check($sformatf("stream_head%0d", k), TX_DATA, (k < 3) ? (8'h21 + 8'(k)) : (8'h30 + 8'(k - 3)));
      step();
      check($sformatf("stream_level%0d", k), LEVEL, 3);
    end
    SENDER_WRITE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stream_tail%0d", k), TX_DATA, 8'h37 + 8'(k));
      step();
    end
    check_idle("stream_done");

    // 5. empty write latency with the shifter ready
    WR_DATA = 8'h5C;
    SENDER_WRITE = 1'b1;
    TX_READY = 1'b1;
    check("lat_c0_valid", TX_VALID, 0);
    step();
    SENDER_WRITE = 1'b0;
    check("lat_c1_valid", TX_VALID, 1);
    check("lat_c1_data", TX_DATA, 8'h5C);
    check("lat_c1_level", LEVEL, 1);
    step();
    check_idle("lat_c2");
    TX_READY = 1'b0;

    // 6. asynchronous reset between edges at level 5
    for (int i = 0; i < 5; i++) begin
      WR_DATA = 8'h41 + 8'(i);
      SENDER_WRITE = 1'b1;
      step();
    end
    SENDER_WRITE = 1'b0;
    check("mid_level", LEVEL, 5);
    #2 CLR = 1'b1;
    #1;
    check_idle("mid_async");
    #1 CLR = 1'b0;
    step();
    check_idle("mid_after");
    WR_DATA = 8'h3E;
    SENDER_WRITE = 1'b1;
    step();
    SENDER_WRITE = 1'b0;
    check("mid_data", TX_DATA, 8'h3E);
    check("mid_level1", LEVEL, 1);
    TX_READY = 1'b1;
    step();
    check_idle("mid_only");
    TX_READY = 1'b0;

    // overflow beats a same-cycle ERR_CLR
    for (int i = 0; i < 8; i++) begin
      WR_DATA = 8'(i);
      SENDER_WRITE = 1'b1;
      step();
    end
    ERR_CLR = 1'b1;
    step();
    SENDER_WRITE = 1'b0;
    check("prio_ovf", OVERFLOW, 1);
    check("prio_level", LEVEL, 8);
    step();
    ERR_CLR = 1'b0;
    check("prio_clr", OVERFLOW, 0);
    check("prio_full", SENDER_FULL_STATE, 1);
    check("prio_bfull", SENDER_BUFFER_FULL_STATE, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
